// File: rtl/dff_share_arb.sv
// Round-robin arbiter that sequences N producers onto one shared W-bit capture
// register, holding each captured value valid for HOLD cycles before re-arbitrating.
module dff_share_arb #(
  parameter int N    = 4,
  parameter int W    = 8,
  parameter int HOLD = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       data_in,
  input  logic                 flush,
  output logic [N-1:0]         gnt,
  output logic [W-1:0]         q,
  output logic                 q_valid,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int PW = $clog2(N);
  localparam int CW = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   ptr_q, ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [N-1:0]    gnt_d;
  logic [W-1:0]    q_d;
  logic [PW-1:0]   owner_d;
  logic [PW-1:0]   sel;
  logic            found;
  int              scan_idx;

  // Rotating scan starting at ptr; the first requester found wins.
  // NOTE: every variable written here gets a default first so no latch is inferred.
  always_comb begin
    sel      = '0;
    found    = 1'b0;
    scan_idx = 0;
    for (int k = 0; k < N; k++) begin
      scan_idx = int'(ptr_q) + k;
      if (scan_idx >= N) scan_idx = scan_idx - N;
      if (!found && req[scan_idx]) begin
        found = 1'b1;
        sel   = PW'(scan_idx);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = '0;
    q_d     = q;
    owner_d = owner;
    case (state_q)
      S_IDLE: begin
        // flush in IDLE suppresses arbitration for that edge only.
        if (!flush && found) begin
          state_d    = S_HOLD;
          gnt_d[sel] = 1'b1;
          q_d        = data_in[int'(sel)*W +: W];
          owner_d    = sel;
          cnt_d      = CW'(HOLD - 1);
        end
      end
      S_HOLD: begin
        if (flush || cnt_q == '0) begin
          state_d = S_IDLE;
          ptr_d   = (owner == PW'(N - 1)) ? '0 : owner + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      q       <= '0;
      owner   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      q       <= q_d;
      owner   <= owner_d;
    end
  end

  assign q_valid = (state_q == S_HOLD);
  assign busy    = (state_q == S_HOLD);

endmodule

// File: tb/tb_dff_share_arb.sv
// Self-checking bench for dff_share_arb: directed scenarios followed by random traffic,
// all compared against a transaction-level model of grants and hold windows.
module tb_dff_share_arb;

  localparam int N    = 4;
  localparam int W    = 8;
  localparam int HOLD = 3;
  localparam int DW   = N * W;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic [N-1:0]         req = '0;
  logic [DW-1:0]        data_in = '0;
  logic                 flush = 1'b0;
  logic [N-1:0]         gnt;
  logic [W-1:0]         q;
  logic                 q_valid;
  logic [$clog2(N)-1:0] owner;
  logic                 busy;

  dff_share_arb #(.N(N), .W(W), .HOLD(HOLD)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in), .flush(flush),
    .gnt(gnt), .q(q), .q_valid(q_valid), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Model: m_left counts the valid cycles still owed to the current grant (0 = free).
  int         m_ptr, m_left, m_owner;
  logic [W-1:0] m_q;
  logic [N-1:0] m_gnt;
  int         gq[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_ptr = 0; m_left = 0; m_owner = 0; m_q = '0; m_gnt = '0;
  endtask

  task automatic model_edge();
    int sel = -1;
    m_gnt = '0;
    if (m_left == 0) begin
      if (!flush && req != '0) begin
        for (int k = 0; k < N; k++)
          if (sel < 0 && req[(m_ptr + k) % N]) sel = (m_ptr + k) % N;
        m_gnt[sel] = 1'b1;
        m_q        = data_in[sel*W +: W];
        m_owner    = sel;
        m_left     = HOLD;
      end
    end else if (flush || m_left == 1) begin
      m_left = 0;
      m_ptr  = (m_owner + 1) % N;
    end else begin
      m_left--;
    end
  endtask

  task automatic check_outputs(input string ph);
    check({ph, "_gnt"},     32'(gnt),            32'(m_gnt));
    check({ph, "_q"},       32'(q),              32'(m_q));
    check({ph, "_q_valid"}, 32'(q_valid),        32'(m_left != 0));
    check({ph, "_busy"},    32'(busy),           32'(m_left != 0));
    check({ph, "_owner"},   32'(owner),          32'(m_owner));
    check({ph, "_onehot"},  32'($onehot0(gnt)),  32'h1);
  endtask

  // One clock: model advances on the edge, DUT is sampled on the falling edge.
  task automatic step(input string ph);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs(ph);
    for (int k = 0; k < N; k++) if (gnt[k]) gq.push_back(k);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    gq.delete();
  endtask

  initial begin
    int exp_rr[5] = '{0, 1, 2, 3, 0};

    @(negedge clk);
    do_reset();

    // Single request from requester 2.
    data_in[2*W +: W] = 8'hA5;
    req = 4'b0100;
    step("t1");
    check("t1_gnt_const",   32'(gnt),   32'h4);
    check("t1_q_const",     32'(q),     32'hA5);
    check("t1_owner_const", 32'(owner), 32'h2);
    req = '0;
    repeat (2) step("t1_hold");
    check("t1_last_valid", 32'(q_valid), 32'h1);
    step("t1_exit");
    check("t1_released", 32'(busy), 32'h0);
    gq.delete();
    req = 4'b1001;
    step("t1_ptr");
    check("t1_ptr_is_3", 32'(gq.size() > 0 ? gq[0] : -1), 32'd3);
    req = '0;
    repeat (3) step("t1_drain");

    // Round-robin fairness with all requesters active.
    do_reset();
    for (int i = 0; i < N; i++) data_in[i*W +: W] = 8'(8'h10 + i);
    req = 4'b1111;
    repeat (20) step("t2");
    check("t2_grant_count", 32'(gq.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (gq.size() > i) check($sformatf("t2_order%0d", i), 32'(gq[i]), 32'(exp_rr[i]));
    req = '0;

    // Wrap: after owner 3, pointer restarts at 0 and skips to 2.
    do_reset();
    req = 4'b1000;
    step("t3_a");
    req = '0;
    repeat (3) step("t3_a_hold");
    gq.delete();
    req = 4'b0101;
    repeat (8) step("t3_b");
    check("t3_count", 32'(gq.size()), 32'd2);
    check("t3_first",  32'(gq.size() > 0 ? gq[0] : -1), 32'd0);
    check("t3_second", 32'(gq.size() > 1 ? gq[1] : -1), 32'd2);
    req = '0;
    repeat (4) step("t3_drain");

    // Late request mid-hold; captured data must not follow data_in.
    do_reset();
    data_in[0 +: W] = 8'h55;
    req = 4'b0001;
    step("t4_grant");
    req = 4'b0010;
    data_in[0 +: W] = 8'h77;
    data_in[W +: W] = 8'h66;
    step("t4_hold1");
    check("t4_frozen1", 32'(q), 32'h55);
    step("t4_hold2");
    check("t4_frozen2", 32'(q), 32'h55);
    step("t4_idle");
    check("t4_no_gnt_idle", 32'(gnt), 32'h0);
    step("t4_late");
    check("t4_late_gnt", 32'(gnt), 32'h2);
    check("t4_late_q",   32'(q),   32'h66);
    req = '0;
    repeat (3) step("t4_drain");

    // flush on the second hold cycle, then flush in IDLE blocks a pending request.
    data_in[2*W +: W] = 8'hC3;
    req = 4'b0100;
    step("t5_grant");
    req = '0;
    step("t5_hold1");
    flush = 1'b1;
    step("t5_flush");
    flush = 1'b0;
    check("t5_valid_dropped", 32'(q_valid), 32'h0);
    check("t5_q_kept",        32'(q),       32'hC3);
    req = 4'b1001;
    flush = 1'b1;
    step("t5_idle_flush");
    check("t5_idle_no_gnt", 32'(gnt), 32'h0);
    flush = 1'b0;
    step("t5_after");
    check("t5_ptr_gnt", 32'(gnt), 32'h8);
    req = '0;

    // Asynchronous reset between edges while holding.
    step("t6_hold");
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check("t6_q",       32'(q),       32'h0);
    check("t6_q_valid", 32'(q_valid), 32'h0);
    check("t6_gnt",     32'(gnt),     32'h0);
    check("t6_owner",   32'(owner),   32'h0);
    check("t6_busy",    32'(busy),    32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    req = 4'b1000;
    step("t6_regrant");
    check("t6_owner3", 32'(owner), 32'h3);
    req = '0;
    repeat (3) step("t6_drain");

    // Random traffic with occasional flushes and resets.
    repeat (600) begin
      req     = N'($urandom);
      data_in = DW'($urandom);
      flush   = ($urandom_range(7) == 0);
      if ($urandom_range(99) == 0) do_reset();
      step("rnd");
    end
    flush = 1'b0;
    req   = '0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dff_share_arb.md
Name: dff_share_arb

Overview:
- Round-robin arbiter and sequencer for one shared W-bit D-flip-flop capture register.
- N requesters compete to load the register.
- The winner's data is captured on the grant edge and held stable with a valid flag for HOLD cycles.
- The register is then released and the priority pointer rotates. The block sits between multiple producers and the single capture register feeding downstream logic.

Parameters:
- N, 4: number of requesters (2..16).
- W, 8: data width of the shared register.
- HOLD, 3: cycles q_valid stays high per grant (>=1).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- req  input  N  per-requester request; level, held until own gnt bit.
- data_in  input  N*W  requester i data on bits [i*W +: W].
- flush  input  1  synchronous abort of current hold.
- gnt  output  N  one-hot, one-cycle grant pulse.
- q  output  W  shared register contents.
- q_valid  output  1  q holds a live granted value.
- owner  output  clog2(N)  index of last granted requester.
- busy  output  1  high in HOLD state.

Behaviour:
- Reset (rst_n low, takes effect immediately regardless of clk):
  - State=IDLE; ptr=0; hold counter=0.
  - gnt=0, q=0, q_valid=0, owner=0, busy=0.
  - Reset mid-HOLD aborts with no gnt and no pointer update.
- States: IDLE, HOLD.
- IDLE, arbitration:
  - At a rising edge with any req bit high, select the first set bit scanning ptr, ptr+1, …, N-1, 0, …, ptr-1.
  - After that edge: gnt[sel]=1 for exactly that cycle; q=data_in[sel]; q_valid=1; owner=sel; busy=1; counter=HOLD-1; state=HOLD.
  - Latency: one edge from sampled req to gnt/q_valid.
- IDLE, no request: all outputs hold; q keeps its last value.
- HOLD:
  - gnt=0. q and owner are frozen; data_in changes are ignored.
  - Each edge with counter>0: decrement.
  - Edge with counter==0: q_valid=0, busy=0, ptr=(owner+1) mod N (N-1 wraps to 0), state=IDLE.
  - q_valid is high for exactly HOLD cycles.
  - At least one IDLE cycle follows each hold, so peak throughput is one grant per HOLD+1 cycles.
- Requests during HOLD are neither queued nor lost. req is level; an un-granted requester keeps req high and is arbitrated in the next IDLE.
  - A requester dropping req before its grant gets no grant.
- HOLD=1: q_valid high one cycle; the next edge returns to IDLE.
- flush:
  - In HOLD, a flush high at an edge forces q_valid=0, busy=0, state=IDLE, ptr=(owner+1) mod N. q is retained.
  - flush wins over counter expiry on the same edge; the result is identical.
  - In IDLE, flush high blocks arbitration on that edge: no gnt.
- Requester keeps req high after its gnt: it is treated as a new request. Rotation gives the other requesters priority first.
- gnt is always zero or one-hot; q_valid==busy at all times.

Test Plan (N=4, W=8, HOLD=3):
1. Reset then single request:
   - Stimulus: reset; req=4'b0100, data_in[2]=8'hA5.
   - Response: one edge later gnt=4'b0100 for 1 cycle, q=8'hA5, owner=2, q_valid high 3 cycles, then busy=0, ptr=3.
2. Round-robin fairness:
   - Stimulus: req=4'b1111 held with data 8'h10/8'h11/8'h12/8'h13.
   - Response: grants in order 0,1,2,3,0; each q_valid burst is 3 cycles separated by 1 idle cycle; owner sequence 0,1,2,3,0.
3. Wrap and pointer skip:
   - Stimulus: after a grant to owner=3 (ptr=0), req=4'b0101.
   - Response: grant 0 first, then grant 2.
4. Late request and data freeze:
   - Stimulus: req[1] raised mid-HOLD of owner 0; data_in[0] changes during HOLD.
   - Response: q stays at captured value; gnt[1] pulses only after the idle cycle.
5. flush:
   - Stimulus: flush pulsed on 2nd HOLD cycle.
   - Response: q_valid=0 next edge, q retained, ptr=owner+1; flush in IDLE with req pending produces no gnt that edge.
6. Async reset mid-HOLD:
   - Stimulus: rst_n low between edges during HOLD.
   - Response: q=0, q_valid=0, gnt=0, owner=0 immediately; after release, req=4'b1000 is granted from ptr=0 (owner=3).
